regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter A_WIDTH, default 4, address width; depth = 2**A_WIDTH words.
REQ-003 SHALL have parameter ZERO_REG, default 0; when 1, word 0 is hardwired to zero.
REQ-004 SHALL have port clk  input  1  clock; all state changes on posedge.
REQ-005 SHALL have port clr  input  1  reset; one clock, reset is synchronous and active-low.
REQ-006 SHALL have ports rd0_addr, rd1_addr  input  A_WIDTH  read port addresses.
REQ-007 SHALL have ports rd0_data, rd1_data  output  D_WIDTH  read data, combinational.
REQ-008 SHALL have ports rd0_ready, rd1_ready  output  1  addressed word not busy (valid).
REQ-009 SHALL have ports wr0_en, wr1_en  input  1  write-back strobes.
REQ-010 SHALL have ports wr0_addr, wr1_addr  input  A_WIDTH  write-back addresses.
REQ-011 SHALL have ports wr0_data, wr1_data  input  D_WIDTH  write-back data.
REQ-012 SHALL have port iss_en  input  1  request to reserve a destination word.
REQ-013 SHALL have port iss_addr  input  A_WIDTH  destination to reserve.
REQ-014 SHALL have port iss_ack  output  1  reservation accepted this cycle, combinational.
REQ-015 SHALL have port busy_cnt  output  A_WIDTH+1  number of words currently busy, registered.

Function
REQ-016 SHALL hold 2**A_WIDTH data words plus one busy bit per word.
REQ-017 SHALL drive rdN_data = stored word at rdN_addr with zero latency; rdN_ready = !busy[rdN_addr].
REQ-018 SHALL write wrN_data to wrN_addr at posedge when wrN_en=1 and clear busy[wrN_addr].
REQ-019 SHALL, when wr0_en and wr1_en target the same address, store wr1_data (port 1 wins).
REQ-020 SHALL assert iss_ack = iss_en && !busy[iss_addr] (registered busy); on ack set busy[iss_addr] at posedge.
REQ-021 SHALL, on iss_en to a busy word, deassert iss_ack and change no state; requester retries.
REQ-022 SHALL, on accepted issue and write to the same address in one cycle, store the data and leave busy set (issue wins).
REQ-023 SHALL update busy_cnt each cycle by +1 per newly set bit and -1 per busy bit cleared (0..2 per cycle); writes to non-busy words do not decrement.
REQ-024 SHALL never let busy_cnt wrap: range 0..2**A_WIDTH.
REQ-025 SHALL, with ZERO_REG=1, read word 0 as 0 with ready=1, ignore writes to 0, and ack issues to 0 without setting busy.

Reset
REQ-026 SHALL, on posedge clk with clr=0, zero all words, clear all busy bits and set busy_cnt=0; clr=0 overrides simultaneous writes and issues.
REQ-027 SHALL, after reset, present rdN_data=0, rdN_ready=1, iss_ack=iss_en.

Configuration
REQ-028 SHALL, with REGFILE_SB_BYPASS_EN defined, forward same-cycle write data to a matching read port (wr1 over wr0 over storage) and drive that port's ready=1.
REQ-029 SHALL, without REGFILE_SB_BYPASS_EN, return pre-write storage and registered busy state on reads.

Structure
REQ-030 SHALL place default D_WIDTH/A_WIDTH constants and port-priority encoding in package regfile_sb_pkg.
REQ-031 SHALL implement busy bits, iss_ack and busy_cnt in sub-module regfile_sb_scoreboard.

Verification
REQ-032 Reset: write 0x5A to addr 3, then clr=0 one cycle -> rd0_addr=3 gives 0x00, ready=1, busy_cnt=0.
REQ-033 Dual-write collision: wr0 (addr 5, 0x11) and wr1 (addr 5, 0x22) same cycle -> next cycle rd 5 = 0x22.
REQ-034 Scoreboard: issue addr 7 -> iss_ack=1, next cycle rd1_ready=0, busy_cnt=1; reissue 7 -> iss_ack=0; write 7 = 0x3C -> ready=1, busy_cnt=0, data 0x3C.
REQ-035 Double retire: words 2 and 9 busy (cnt=2); wr0→2, wr1→9 same cycle -> busy_cnt=0 next cycle.
REQ-036 Bypass: write addr 4 = 0xA5 while rd0_addr=4 -> same cycle 0xA5 with BYPASS_EN, old value without.
REQ-037 ZERO_REG=1: write 0xFF to addr 0, issue addr 0 -> rd 0 = 0x00, iss_ack=1, busy_cnt unchanged.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg -- shared constants and write-port priority for regfile_sb.
//   D_WIDTH_DEF / A_WIDTH_DEF : default word and address widths
//   wsel_e / wsel()           : which write-back port owns a word this cycle
//                               (port 1 beats port 0 beats stored value)
package regfile_sb_pkg;

  localparam int D_WIDTH_DEF = 8;
  localparam int A_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    WSEL_NONE = 2'd0,
    WSEL_WR0  = 2'd1,
    WSEL_WR1  = 2'd2
  } wsel_e;

  function automatic wsel_e wsel(input logic hit0, input logic hit1);
    if (hit1) return WSEL_WR1;
    if (hit0) return WSEL_WR0;
    return WSEL_NONE;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard -- busy bits, issue handshake and busy counter.
//   clk, clr        : clock, synchronous active-low reset
//   wrN_en/wrN_addr : write-backs; retire the addressed word if busy
//   iss_en/iss_addr : reserve a destination word
//   iss_ack         : reservation accepted (combinational, from registered busy)
//   busy            : registered busy vector, one bit per word
//   busy_cnt        : registered number of busy words
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int A_WIDTH  = A_WIDTH_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    wr0_en,
  input  logic [A_WIDTH-1:0]      wr0_addr,
  input  logic                    wr1_en,
  input  logic [A_WIDTH-1:0]      wr1_addr,
  input  logic                    iss_en,
  input  logic [A_WIDTH-1:0]      iss_addr,
  output logic                    iss_ack,
  output logic [(2**A_WIDTH)-1:0] busy,
  output logic [A_WIDTH:0]        busy_cnt
);

  localparam int DEPTH = 2**A_WIDTH;
  localparam int CW    = A_WIDTH + 1;

  logic             set_en, clr0, clr1;
  logic [DEPTH-1:0] set_vec, clr_vec;

  always_comb begin
    iss_ack = iss_en && !busy[iss_addr];
    // word 0 as a constant register acks but never becomes busy
    set_en  = iss_ack && !(ZERO_REG != 0 && iss_addr == '0);
    // Only already-busy words retire; a word being reserved is not busy, so
    // a same-cycle write to it cannot clear the new reservation.
    clr0    = wr0_en && busy[wr0_addr];
    // both ports retiring the same word count once
    clr1    = wr1_en && busy[wr1_addr] && !(wr0_en && wr0_addr == wr1_addr);
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[iss_addr] = 1'b1;
    if (clr0)   clr_vec[wr0_addr] = 1'b1;
    if (clr1)   clr_vec[wr1_addr] = 1'b1;
  end

  // The counter tracks the popcount of busy exactly, so it stays in 0..DEPTH.
  always_ff @(posedge clk) begin
    if (!clr) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= (busy & ~clr_vec) | set_vec;
      busy_cnt <= busy_cnt + CW'(set_en) - CW'(clr0) - CW'(clr1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- 2-read / 2-write register file with a per-word busy scoreboard.
//   clk, clr            : clock, synchronous active-low reset
//   rdN_addr/rdN_data   : combinational read ports
//   rdN_ready           : addressed word not reserved
//   wrN_en/addr/data    : write-back ports (port 1 wins on collision)
//   iss_en/iss_addr     : destination reservation request
//   iss_ack             : reservation accepted this cycle
//   busy_cnt            : number of reserved words (registered)
// Build option: define REGFILE_SB_BYPASS_EN to forward same-cycle write data
// (and ready=1) to a matching read port.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int A_WIDTH  = A_WIDTH_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [A_WIDTH-1:0] rd0_addr,
  input  logic [A_WIDTH-1:0] rd1_addr,
  output logic [D_WIDTH-1:0] rd0_data,
  output logic [D_WIDTH-1:0] rd1_data,
  output logic               rd0_ready,
  output logic               rd1_ready,
  input  logic               wr0_en,
  input  logic               wr1_en,
  input  logic [A_WIDTH-1:0] wr0_addr,
  input  logic [A_WIDTH-1:0] wr1_addr,
  input  logic [D_WIDTH-1:0] wr0_data,
  input  logic [D_WIDTH-1:0] wr1_data,
  input  logic               iss_en,
  input  logic [A_WIDTH-1:0] iss_addr,
  output logic               iss_ack,
  output logic [A_WIDTH:0]   busy_cnt
);

  localparam int DEPTH = 2**A_WIDTH;

  logic [DEPTH-1:0]   busy;
  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   hit0, hit1;

  regfile_sb_scoreboard #(
    .A_WIDTH  (A_WIDTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .clr      (clr),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ack  (iss_ack),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // One-hot write decode per port; word 0 is excluded when it is a constant.
  always_comb begin
    for (int w = 0; w < DEPTH; w++) begin
      hit0[w] = wr0_en && wr0_addr == A_WIDTH'(w) && !(ZERO_REG != 0 && w == 0);
      hit1[w] = wr1_en && wr1_addr == A_WIDTH'(w) && !(ZERO_REG != 0 && w == 0);
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < DEPTH; w++) begin
      if (!clr) mem[w] <= '0;
      else begin
        unique case (wsel(hit0[w], hit1[w]))
          WSEL_WR1: mem[w] <= wr1_data;
          WSEL_WR0: mem[w] <= wr0_data;
          default:  ;
        endcase
      end
    end
  end

  // Read ports handled as a lane array
  logic [A_WIDTH-1:0] ra [2];
  logic [D_WIDTH-1:0] rd [2];
  logic               rr [2];

  assign ra[0]     = rd0_addr;
  assign ra[1]     = rd1_addr;
  assign rd0_data  = rd[0];
  assign rd1_data  = rd[1];
  assign rd0_ready = rr[0];
  assign rd1_ready = rr[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd[p] = mem[ra[p]];
      rr[p] = !busy[ra[p]];
      if (ZERO_REG != 0 && ra[p] == '0) begin
        rd[p] = '0;
        rr[p] = 1'b1;
      end
`ifdef REGFILE_SB_BYPASS_EN
      // A write that reset is about to squash must not be forwarded.
      if (clr) begin
        unique case (wsel(hit0[ra[p]], hit1[ra[p]]))
          WSEL_WR1: begin rd[p] = wr1_data; rr[p] = 1'b1; end
          WSEL_WR0: begin rd[p] = wr0_data; rr[p] = 1'b1; end
          default:  ;
        endcase
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] rd0_addr, rd1_addr, wr0_addr, wr1_addr, iss_addr;
  logic       wr0_en, wr1_en, iss_en;
  logic [7:0] wr0_data, wr1_data;

  // index 0: ZERO_REG=0 instance, index 1: ZERO_REG=1 instance
  logic [1:0][7:0] o_rd0, o_rd1;
  logic [1:0]      o_rdy0, o_rdy1, o_ack;
  logic [1:0][4:0] o_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.D_WIDTH(8), .A_WIDTH(4), .ZERO_REG(0)) dut (
    .clk(clk), .clr(clr),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(o_rd0[0]), .rd1_data(o_rd1[0]),
    .rd0_ready(o_rdy0[0]), .rd1_ready(o_rdy1[0]),
    .wr0_en(wr0_en), .wr1_en(wr1_en),
    .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ack(o_ack[0]), .busy_cnt(o_cnt[0])
  );

  regfile_sb #(.D_WIDTH(8), .A_WIDTH(4), .ZERO_REG(1)) dutz (
    .clk(clk), .clr(clr),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(o_rd0[1]), .rd1_data(o_rd1[1]),
    .rd0_ready(o_rdy0[1]), .rd1_ready(o_rdy1[1]),
    .wr0_en(wr0_en), .wr1_en(wr1_en),
    .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ack(o_ack[1]), .busy_cnt(o_cnt[1])
  );

  // Reference model: plain word array plus set of reserved words
  logic  [7:0]  m_mem  [2][16];
  bit    [15:0] m_busy [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit is_zr(input int i, input logic [3:0] a);
    return (i == 1) && (a == 4'd0);
  endfunction

  task automatic exp_rd(input int i, input logic [3:0] a, output logic [7:0] d, output logic r);
    d = is_zr(i, a) ? 8'h00 : m_mem[i][a];
    r = is_zr(i, a) ? 1'b1 : !m_busy[i][a];
`ifdef REGFILE_SB_BYPASS_EN
    if (clr && wr1_en && wr1_addr == a && !is_zr(i, a)) begin d = wr1_data; r = 1'b1; end
    else if (clr && wr0_en && wr0_addr == a && !is_zr(i, a)) begin d = wr0_data; r = 1'b1; end
`endif
  endtask

  task automatic compare(input int i);
    logic [7:0] d;
    logic       r;
    exp_rd(i, rd0_addr, d, r);
    chk($sformatf("u%0d rd0_data", i), o_rd0[i], d);
    chk($sformatf("u%0d rd0_ready", i), o_rdy0[i], r);
    exp_rd(i, rd1_addr, d, r);
    chk($sformatf("u%0d rd1_data", i), o_rd1[i], d);
    chk($sformatf("u%0d rd1_ready", i), o_rdy1[i], r);
    chk($sformatf("u%0d iss_ack", i), o_ack[i], iss_en && !m_busy[i][iss_addr]);
    chk($sformatf("u%0d busy_cnt", i), o_cnt[i], $countones(m_busy[i]));
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (!clr) begin
        for (int w = 0; w < 16; w++) m_mem[i][w] = 8'h00;
        m_busy[i] = '0;
      end else begin
        bit ack;
        ack = iss_en && !m_busy[i][iss_addr];
        if (wr0_en && !is_zr(i, wr0_addr)) begin
          m_mem[i][wr0_addr] = wr0_data; m_busy[i][wr0_addr] = 1'b0;
        end
        if (wr1_en && !is_zr(i, wr1_addr)) begin
          m_mem[i][wr1_addr] = wr1_data; m_busy[i][wr1_addr] = 1'b0;
        end
        if (ack && !is_zr(i, iss_addr)) m_busy[i][iss_addr] = 1'b1;
      end
    end
  endtask

  // One cycle: compare against model, advance model, move to next drive point
  task automatic tick(input bit do_chk);
    #1;
    if (do_chk) begin
      compare(0);
      compare(1);
    end
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [7:0] d);
    wr0_en = 1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [7:0] d);
    wr1_en = 1; wr1_addr = a; wr1_data = d;
  endtask

  task automatic iss(input logic [3:0] a);
    iss_en = 1; iss_addr = a;
  endtask

  initial begin
    clr = 0; idle();
    rd0_addr = 0; rd1_addr = 0; wr0_addr = 0; wr1_addr = 0; iss_addr = 0;
    wr0_data = 0; wr1_data = 0;
    tick(0);

    // post-reset state
    clr = 1; rd0_addr = 3; rd1_addr = 3;
    #1;
    chk("rst rd0_data", o_rd0[0], 8'h00);
    chk("rst rd0_ready", o_rdy0[0], 1'b1);
    chk("rst busy_cnt", o_cnt[0], 5'd0);
    chk("rst iss_ack idle", o_ack[0], 1'b0);
    iss(2);
    #1 chk("rst iss_ack req", o_ack[0], 1'b1);
    tick(1);

    // write then reset clears data and busy
    idle(); wr0(3, 8'h5A);
    tick(1);
    idle();
    #1 chk("pre-clr rd0_data", o_rd0[0], 8'h5A);
    chk("pre-clr busy_cnt", o_cnt[0], 5'd1);
    clr = 0; wr1(3, 8'h77); iss(4);
    tick(1);
    clr = 1; idle();
    #1 chk("clr rd0_data", o_rd0[0], 8'h00);
    chk("clr rd0_ready", o_rdy0[0], 1'b1);
    chk("clr busy_cnt", o_cnt[0], 5'd0);

    // dual-write collision
    wr0(5, 8'h11); wr1(5, 8'h22);
    tick(1);
    idle(); rd0_addr = 5;
    #1 chk("collide rd", o_rd0[0], 8'h22);

    // issue / reissue / retire on word 7
    iss(7); rd1_addr = 7;
    #1 chk("iss7 ack", o_ack[0], 1'b1);
    tick(1);
    #1 chk("iss7 rd1_ready", o_rdy1[0], 1'b0);
    chk("iss7 busy_cnt", o_cnt[0], 5'd1);
    chk("reiss7 ack", o_ack[0], 1'b0);
    tick(1);
    idle(); wr0(7, 8'h3C);
    tick(1);
    idle();
    #1 chk("ret7 rd1_data", o_rd1[0], 8'h3C);
    chk("ret7 rd1_ready", o_rdy1[0], 1'b1);
    chk("ret7 busy_cnt", o_cnt[0], 5'd0);

    // double retire
    iss(2); tick(1);
    iss(9); tick(1);
    idle();
    #1 chk("dbl busy_cnt 2", o_cnt[0], 5'd2);
    wr0(2, 8'hAA); wr1(9, 8'hBB);
    tick(1);
    idle();
    #1 chk("dbl busy_cnt 0", o_cnt[0], 5'd0);

    // issue and write same word: data stored, stays busy
    iss(6); wr0(6, 8'h66);
    #1 chk("iss+wr ack", o_ack[0], 1'b1);
    tick(1);
    idle(); rd0_addr = 6;
    #1 chk("iss+wr data", o_rd0[0], 8'h66);
    chk("iss+wr ready", o_rdy0[0], 1'b0);
    chk("iss+wr busy_cnt", o_cnt[0], 5'd1);
    wr1(6, 8'h67); tick(1);
    idle();

    // bypass vs pre-write storage
    wr0(4, 8'h10); tick(1);
    idle(); wr0(4, 8'hA5); rd0_addr = 4;
`ifdef REGFILE_SB_BYPASS_EN
    #1 chk("bypass rd0", o_rd0[0], 8'hA5);
`else
    #1 chk("bypass rd0", o_rd0[0], 8'h10);
`endif
    tick(1);
    idle();
    #1 chk("post-wr rd0", o_rd0[0], 8'hA5);

    // hardwired word 0
    wr0(0, 8'hFF); iss(0); rd0_addr = 0;
    #1 chk("zr iss_ack", o_ack[1], 1'b1);
    tick(1);
    idle();
    #1 chk("zr rd0_data", o_rd0[1], 8'h00);
    chk("zr rd0_ready", o_rdy0[1], 1'b1);
    chk("zr busy_cnt", o_cnt[1], 5'd0);
    chk("nz rd0_data", o_rd0[0], 8'hFF);
    chk("nz busy_cnt", o_cnt[0], 5'd1);
    tick(1);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      bit narrow;
      narrow   = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 99) != 0);
      wr0_en   = ($urandom_range(0, 2) == 0);
      wr1_en   = ($urandom_range(0, 2) == 0);
      iss_en   = ($urandom_range(0, 1) == 0);
      wr0_addr = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      wr1_addr = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      iss_addr = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      wr0_data = 8'($urandom);
      wr1_data = 8'($urandom);
      rd0_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 4'($urandom_range(0, 15));
      rd1_addr = ($urandom_range(0, 3) == 0) ? wr1_addr : iss_addr;
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
